// File: rtl/i2s_pkg.sv
// Shared constants, frame geometry and sample-pair type for the I2S transmit path.
package i2s_pkg;

  // Audio format and clock ratios
  localparam int unsigned SAMPLE_W    = 24;
  localparam int unsigned BITS_PER_CH = 32;
  localparam int unsigned SCK_HALF    = 16;
  localparam int unsigned MCLK_HALF   = 2;

  // Frame geometry derived from the ratios above
  localparam int unsigned FRAME    = 4 * SCK_HALF * BITS_PER_CH;
  localparam int unsigned FC_W     = $clog2(FRAME);
  localparam int unsigned SLOT_W   = $clog2(2 * BITS_PER_CH);
  localparam int unsigned POS_W    = $clog2(BITS_PER_CH);
  localparam int unsigned IDX_W    = $clog2(SAMPLE_W);
  localparam int unsigned MCLK_BIT = $clog2(MCLK_HALF);
  localparam int unsigned SCK_BIT  = $clog2(SCK_HALF);
  localparam int unsigned SLOT_LSB = $clog2(2 * SCK_HALF);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME - 1);

  // One stereo sample pair as carried on the input handshake and in the shifter
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  // Serial bit for channel ch at slot position pos: one-bit delay, MSB first, zero pad
  function automatic logic pair_bit(input pair_t p, input logic ch,
                                    input logic [POS_W-1:0] pos);
    logic [SAMPLE_W-1:0] w;
    w = ch ? p.right : p.left;
    pair_bit = 1'b0;
    if ((pos != '0) && (32'(pos) <= SAMPLE_W)) begin
      pair_bit = w[IDX_W'(SAMPLE_W - 32'(pos))];
    end
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Frame counter and registered audio clock decode (mclk, sck, lrck).
// Pins are registered from the next counter value so they line up with fc.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic [SLOT_W-1:0] slot_c,
  output logic              load_c
);

  logic [FC_W-1:0] fc;
  logic [FC_W-1:0] fc_nxt;

  // Next count: wrap at end of frame, park at FRAME-1 while disabled
  always_comb begin
    fc_nxt = FC_LAST;
    load_c = 1'b0;
    if (en) begin
      load_c = (fc == FC_LAST);
      fc_nxt = load_c ? '0 : fc + FC_W'(1);
    end
  end

  // Slot index of the upcoming cycle, consumed by the serial data decode
  assign slot_c = fc_nxt[FC_W-1:SLOT_LSB];

  // Counter and pin registers; pins forced low while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc   <= FC_LAST;
      mclk <= 1'b0;
      sck  <= 1'b0;
      lrck <= 1'b0;
    end else begin
      fc   <= fc_nxt;
      mclk <= en & fc_nxt[MCLK_BIT];
      sck  <= en & fc_nxt[SCK_BIT];
      lrck <= en & fc_nxt[FC_W-1];
    end
  end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: one-entry shadow register, frame shifter and serial output.
module i2s_tx_ctrl
  import i2s_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                mclk,
  output logic                sck,
  output logic                lrck,
  output logic                sdout,
  output logic                frame_start,
  output logic                underrun
);

  logic [SLOT_W-1:0] slot;
  logic              load;
  logic              accept;
  pair_t             shadow;
  pair_t             shifter;

  i2s_clkgen u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mclk   (mclk),
    .sck    (sck),
    .lrck   (lrck),
    .slot_c (slot),
    .load_c (load)
  );

  // s_ready doubles as the shadow-empty flag
  assign accept = s_valid & s_ready;

  // Shadow register: accept wins over a same-cycle load, which has already seen empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      s_ready <= 1'b1;
    end else if (accept) begin
      shadow.left  <= s_left;
      shadow.right <= s_right;
      s_ready      <= 1'b0;
    end else if (load) begin
      s_ready <= 1'b1;
    end
  end

  // Frame load into the shifter with start and underrun strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter     <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load & s_ready;
      if (load) begin
        shifter <= s_ready ? '0 : shadow;
      end
    end
  end

  // Serial data; slot position 0 always decodes to 0, so a same-cycle load is safe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdout <= 1'b0;
    end else begin
      sdout <= en & pair_bit(shifter, slot[SLOT_W-1], slot[POS_W-1:0]);
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl against a frame-phase reference model.
module tb_i2s_tx_ctrl;
  import i2s_pkg::*;

  localparam int FRM = 2048;

  logic        clk;
  logic        rst, en, s_valid;
  logic [23:0] s_left, s_right;
  logic        s_ready, mclk, sck, lrck, sdout, frame_start, underrun;
  logic [6:0]  obs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: frame phase, shadow and current frame words
  int          m_phase;
  bit          m_full;
  logic [23:0] m_sh_l, m_sh_r, m_w_l, m_w_r;
  logic [6:0]  m_exp;

  // Observation helpers
  bit          rec_on, cap_on;
  int          cap_n;
  logic [63:0] cap, v;
  logic        prev_mclk, prev_sck, prev_lrck;
  int          q_mclk[$], q_sck[$], q_lr_rise[$], q_lr_fall[$], q_fs[$], q_ur[$];
  logic [23:0] p_l, p_r;

  i2s_tx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s_left      (s_left),
    .s_right     (s_right),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mclk        (mclk),
    .sck         (sck),
    .lrck        (lrck),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  assign obs = {s_ready, mclk, sck, lrck, sdout, frame_start, underrun};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Expected 64 bits seen on sck rising edges over one frame
  function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  function automatic logic exp_bit(input int ph, input logic [23:0] wl, input logic [23:0] wr);
    int slot, pos;
    logic [23:0] w;
    slot = ph / 32;
    pos  = slot % 32;
    w    = (slot >= 32) ? wr : wl;
    if (pos >= 1 && pos <= 24) return w[5'(24 - pos)];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = FRM - 1;
    m_full  = 1'b0;
    m_sh_l  = '0;
    m_sh_r  = '0;
    m_w_l   = '0;
    m_w_r   = '0;
    m_exp   = 7'b1000000;
  endtask

  // Advance the model by one clock using the inputs held across the edge
  task automatic model_step();
    bit ld, acc, e_fs, e_ur, e_mclk, e_sck, e_lr, e_sd;
    if (rst) begin
      model_reset();
      return;
    end
    ld   = en && (m_phase == FRM - 1);
    acc  = s_valid && !m_full;
    e_fs = ld;
    e_ur = ld && !m_full;
    if (ld) begin
      m_w_l  = m_full ? m_sh_l : 24'h0;
      m_w_r  = m_full ? m_sh_r : 24'h0;
      m_full = 1'b0;
    end
    if (acc) begin
      m_sh_l = s_left;
      m_sh_r = s_right;
      m_full = 1'b1;
    end
    m_phase = en ? (m_phase + 1) % FRM : FRM - 1;
    e_mclk  = en && ((m_phase / 2) % 2 == 1);
    e_sck   = en && ((m_phase / 16) % 2 == 1);
    e_lr    = en && (m_phase >= FRM / 2);
    e_sd    = en && exp_bit(m_phase, m_w_l, m_w_r);
    m_exp   = {!m_full, e_mclk, e_sck, e_lr, e_sd, e_fs, e_ur};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("outputs", 64'(obs), 64'(m_exp));
    if (rec_on) begin
      if (mclk && !prev_mclk) q_mclk.push_back(cyc);
      if (sck && !prev_sck) q_sck.push_back(cyc);
      if (lrck && !prev_lrck) q_lr_rise.push_back(cyc);
      if (!lrck && prev_lrck) q_lr_fall.push_back(cyc);
      if (frame_start) q_fs.push_back(cyc);
      if (underrun) q_ur.push_back(cyc);
    end
    if (cap_on && sck && !prev_sck) begin
      cap = {cap[62:0], sdout};
      cap_n++;
    end
    prev_mclk = mclk;
    prev_sck  = sck;
    prev_lrck = lrck;
  endtask

  task automatic run_capture(input string tag, output logic [63:0] bits);
    cap    = '0;
    cap_n  = 0;
    cap_on = 1'b1;
    for (int i = 0; i < 2100 && cap_n < 64; i++) tick();
    cap_on = 1'b0;
    chk(tag, 64'(cap_n), 64'd64);
    bits = cap;
  endtask

  task automatic wait_fs(input string tag);
    for (int i = 0; i < 2100 && !frame_start; i++) tick();
    chk(tag, 64'(frame_start), 64'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    rec_on = 1'b0; cap_on = 1'b0; cap_n = 0; cap = '0;
    prev_mclk = 1'b0; prev_sck = 1'b0; prev_lrck = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("reset_state", 64'(obs), 64'h40);
    rst = 1'b0;
    tick();

    // Serial format: pair offered before the first load
    s_left = 24'hA5A5A5; s_right = 24'h5A5A5A; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("accept_ready_low", 64'(s_ready), 64'd0);
    en = 1'b1;
    rec_on = 1'b1;
    run_capture("serial_cap", v);
    chk("serial_a5", v, frame_bits(24'hA5A5A5, 24'h5A5A5A));

    // Clock ratios and underrun cadence with no samples offered
    repeat (2 * FRM + 1100) tick();
    rec_on = 1'b0;
    chk("mclk_period", 64'(qat(q_mclk, 1) - qat(q_mclk, 0)), 64'd4);
    chk("mclk_period_late", 64'(qat(q_mclk, q_mclk.size() - 1) - qat(q_mclk, q_mclk.size() - 2)), 64'd4);
    chk("sck_period", 64'(qat(q_sck, 1) - qat(q_sck, 0)), 64'd32);
    chk("lrck_period", 64'(qat(q_lr_rise, 1) - qat(q_lr_rise, 0)), 64'd2048);
    chk("lrck_high", 64'(qat(q_lr_fall, 0) - qat(q_lr_rise, 0)), 64'd1024);
    chk("lrck_after_fs", 64'(qat(q_lr_rise, 0) - qat(q_fs, 0)), 64'd1024);
    chk("fs_period", 64'(qat(q_fs, 1) - qat(q_fs, 0)), 64'd2048);
    chk("fs_count", 64'(q_fs.size()), 64'd4);
    chk("ur_count", 64'(q_ur.size()), 64'd3);
    chk("ur_with_fs_first", 64'(qat(q_ur, 0)), 64'(qat(q_fs, 1)));
    chk("ur_with_fs_last", 64'(qat(q_ur, 2)), 64'(qat(q_fs, 3)));

    // Back-pressure: P1 then P2 back-to-back
    s_left = 24'($urandom); s_right = 24'($urandom); s_valid = 1'b1;
    tick();
    chk("p1_accept", 64'(s_ready), 64'd0);
    p_l = 24'($urandom); p_r = 24'($urandom);
    s_left = p_l; s_right = p_r;
    for (int i = 0; i < 2100 && !s_ready; i++) tick();
    chk("p2_ready_wait", 64'(s_ready), 64'd1);
    chk("ready_at_load", 64'(frame_start), 64'd1);
    tick();
    s_valid = 1'b0;
    chk("p2_accept", 64'(s_ready), 64'd0);
    wait_fs("p2_frame_wait");
    chk("p2_no_underrun", 64'(underrun), 64'd0);
    run_capture("p2_cap", v);
    chk("p2_serial", v, frame_bits(p_l, p_r));

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 5 * FRM; i++) begin
      s_valid = ($urandom_range(0, 199) == 0);
      s_left  = 24'($urandom);
      s_right = 24'($urandom);
      tick();
    end
    s_valid = 1'b0;

    // Collision: pair offered on the load cycle with the shadow empty
    for (int i = 0; i < 3 * FRM && !((m_phase == FRM - 1) && !m_full); i++) tick();
    chk("coll_setup", 64'((m_phase == FRM - 1) && !m_full), 64'd1);
    p_l = 24'($urandom); p_r = 24'($urandom);
    s_left = p_l; s_right = p_r; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("coll_underrun", 64'(underrun), 64'd1);
    chk("coll_fs", 64'(frame_start), 64'd1);
    chk("coll_ready", 64'(s_ready), 64'd0);
    run_capture("coll_zero_cap", v);
    chk("coll_zero_frame", v, 64'd0);
    wait_fs("coll_next_wait");
    chk("coll_next_no_ur", 64'(underrun), 64'd0);
    run_capture("coll_next_cap", v);
    chk("coll_next_serial", v, frame_bits(p_l, p_r));

    // Enable drop mid-frame, then re-raise
    for (int i = 0; i < 3 * FRM && m_phase != 700; i++) tick();
    en = 1'b0;
    tick();
    chk("en_off_pins", 64'({mclk, sck, lrck, sdout}), 64'd0);
    repeat (5) tick();
    s_left = 24'($urandom); s_right = 24'($urandom); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("en_off_accept", 64'(s_ready), 64'd0);
    en = 1'b1;
    tick();
    chk("en_restart_fs", 64'(frame_start), 64'd1);
    chk("en_restart_ur", 64'(underrun), 64'd0);

    // Reset mid-right-channel discards the shadow
    s_left = 24'($urandom); s_right = 24'($urandom); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 3 * FRM && m_phase != 1500; i++) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async", 64'(obs), 64'h40);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_restart_fs", 64'(frame_start), 64'd1);
    chk("rst_discard_ur", 64'(underrun), 64'd1);
    repeat (100) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_ctrl.md
Name: i2s_tx_ctrl

Overview:
Sequencer for the stereo I2S DAC output path (mclk, lrck, sck, sdout). It derives all audio clocks from the 100 MHz system clock and accepts one stereo sample per frame over a valid/ready handshake. It buffers that sample in a one-entry shadow register and serialises it MSB-first in I2S format. It sits between the synth voice mixer and the DAC pins at the top level.

Parameters:
SAMPLE_W, 24, bits per channel sample (two's complement), must be <= BITS_PER_CH-1
BITS_PER_CH, 32, sck periods per channel slot; power of two
SCK_HALF, 16, clk cycles per sck half-period; power of two
MCLK_HALF, 2, clk cycles per mclk half-period; power of two, < SCK_HALF

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-high
en  in  1  run enable; low parks the frame counter and drives the I2S pins low
s_left  in  SAMPLE_W  left sample
s_right  in  SAMPLE_W  right sample
s_valid  in  1  sample pair valid
s_ready  out  1  shadow register empty; a pair is accepted when s_valid && s_ready
mclk  out  1  DAC master clock, clk/(2*MCLK_HALF) = 25 MHz
sck  out  1  serial bit clock, clk/(2*SCK_HALF) = 3.125 MHz
lrck  out  1  word select, 0 = left, 1 = right; frame = 2048 clk ≈ 48.83 kHz
sdout  out  1  serial data, changes on sck falling edge
frame_start  out  1  one-clk pulse when a frame is loaded into the shifter
underrun  out  1  one-clk pulse when a frame load finds the shadow register empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset values: fc = FRAME-1; shadow empty; shifter = 0; s_ready = 1; all pins, frame_start and underrun = 0.
- Frame counter fc: 0..FRAME-1, where FRAME = 4*SCK_HALF*BITS_PER_CH = 2048. It increments each clk while en=1 and wraps FRAME-1 -> 0. While en=0 it holds at FRAME-1.
- Decode from fc:
  - mclk = fc[log2 MCLK_HALF]
  - sck = fc[log2 SCK_HALF]
  - slot b = fc >> log2(2*SCK_HALF), range 0..63
  - lrck = b[log2 BITS_PER_CH]
  - Each slot starts with sck low, so data changes on the sck falling edge and the DAC samples on the rising edge.
- sdout within a channel, position p = b mod BITS_PER_CH:
  - p = 0: 0 (I2S one-bit delay)
  - p = 1..SAMPLE_W: bit SAMPLE_W-p of the channel word (MSB first)
  - p > SAMPLE_W: 0
- Output registration: all pin outputs are registered decodes of fc (one clk latency), so they are mutually aligned. When en=0, the registered pins are 0.
- Load: on a cycle with en=1 and fc=FRAME-1, the shifter takes the shadow register and fc wraps to 0. frame_start pulses on the same cycle.
  - If the shadow register is full, it is marked empty.
  - If it is empty, the shifter loads zeros and underrun pulses with frame_start.
- Handshake: s_ready = !shadow_full. On accept, the shadow register captures s_left/s_right and s_ready drops on the next cycle.
- Accept and load in the same cycle (shadow empty): the load sees empty (zeros + underrun) and the accepted pair stays in the shadow for the next frame. There is no fall-through.
- en: when deasserted mid-frame, fc parks at FRAME-1 on the next cycle and the frame is truncated. The shadow contents and s_ready are unaffected. The first cycle with en=1 performs a load.
- Reset mid-frame: all state returns to reset values immediately; the shadow contents are discarded.

Decomposition:
- Shared package i2s_pkg:
  - SAMPLE_W, BITS_PER_CH, SCK_HALF and MCLK_HALF defaults
  - derived FRAME and fc width (11 bits)
  - typedef for a stereo sample pair
- One natural sub-module, i2s_clkgen: frame counter plus registered mclk/sck/lrck decode, slot index and load strobe.
- Shifter, shadow register and handshake stay in i2s_tx_ctrl.

Test Plan:
- Clock ratios: assert reset, then en=1 with no samples -> mclk period 4 clk, sck period 32 clk, lrck period 2048 clk with 50% duty; first lrck rise 1024 clk after the first frame_start.
- Serial format: offer left=24'hA5A5A5, right=24'h5A5A5A before the first load -> sdout sampled on sck rising edges reads 0, A5A5A5 MSB-first, 7 zeros, then 0, 5A5A5A, 7 zeros; no underrun.
- Underrun: s_valid held 0 -> sdout constant 0 and underrun pulses once every 2048 clk, coincident with frame_start.
- Back-pressure: present pair P1 then P2 back-to-back -> P1 accepted, s_ready low until P1's frame load, P2 accepted the next cycle and sent in the following frame.
- Collision: s_valid rises with the shadow empty on the fc=FRAME-1 cycle -> underrun pulse, zeros sent this frame, the pair is sent in the next frame.
- Reset and en: pulse rst mid-right-channel -> all outputs 0 immediately, s_ready=1. Drop en mid-frame -> pins low the next cycle; re-raise en -> frame_start on the first enabled cycle.
